// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 4-bit sync preamble, DATA_W payload bits MSB first, one GAP cycle.
// Optional even-parity bit after the payload when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx #(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] SYNC_PAT = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              done
);

  // Counter must reach DATA_W-1 in DATA and 3 in SYNC.
  localparam int CNT_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
`ifdef SYNC_FRAME_TX_PARITY_EN
    PAR  = 3'd4,
`endif
    GAP  = 3'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] sh, sh_nxt;
  logic              dout_nxt, dout_en_nxt, done_nxt;
  logic [1:0]        sync_idx;
`ifdef SYNC_FRAME_TX_PARITY_EN
  logic              par, par_nxt;
`endif

  assign in_ready = (state == IDLE);
  assign sync_idx = 2'd2 - cnt[1:0];

  // NOTE: outputs are decoded from the *next* state and registered, so each
  // bit is on dout during the cycle its state is current (latency 1 from accept).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    sh_nxt      = sh;
    dout_nxt    = 1'b0;
    dout_en_nxt = 1'b0;
    done_nxt    = 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt   = SYNC;
          cnt_nxt     = '0;
          sh_nxt      = in_data;
`ifdef SYNC_FRAME_TX_PARITY_EN
          par_nxt     = ^in_data;
`endif
          dout_nxt    = SYNC_PAT[3];
          dout_en_nxt = 1'b1;
        end
      end
      SYNC: begin
        dout_en_nxt = 1'b1;
        if (cnt == SYNC_LAST) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          dout_nxt  = sh[DATA_W-1];
          sh_nxt    = sh << 1;
        end else begin
          cnt_nxt  = cnt + 1'b1;
          dout_nxt = SYNC_PAT[sync_idx];
        end
      end
      DATA: begin
        if (cnt == DATA_LAST) begin
          cnt_nxt = '0;
`ifdef SYNC_FRAME_TX_PARITY_EN
          state_nxt   = PAR;
          dout_nxt    = par;
          dout_en_nxt = 1'b1;
`else
          state_nxt   = GAP;
          done_nxt    = 1'b1;
`endif
        end else begin
          cnt_nxt     = cnt + 1'b1;
          dout_nxt    = sh[DATA_W-1];
          dout_en_nxt = 1'b1;
          sh_nxt      = sh << 1;
        end
      end
`ifdef SYNC_FRAME_TX_PARITY_EN
      PAR: begin
        state_nxt = GAP;
        done_nxt  = 1'b1;
      end
`endif
      GAP: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sh_nxt    = '0;
      end
    endcase
  end

  // NOTE: the payload shift register is plain flops, so it is cleared by reset
  // together with the control state; no stale payload survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      dout    <= 1'b0;
      dout_en <= 1'b0;
      done    <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sh      <= sh_nxt;
      dout    <= dout_nxt;
      dout_en <= dout_en_nxt;
      done    <= done_nxt;
`ifdef SYNC_FRAME_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

endmodule
